note_recorder: RTL

Run-length note recorder/sequencer sitting directly upstream of the tone generator in the music-box datapath. Records the live note index (from the key/octave encoder) as (note, duration) pairs measured in 4 Hz beat ticks. Plays them back as a note-index stream. Its `note` output drives the tone generator's note-select input, values 0..21 with 0 meaning rest.

---
 rtl/note_recorder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/note_recorder.sv
// Run-length note recorder/sequencer feeding the tone generator's note-select input.
// Records (note, duration-in-ticks) pairs and replays them as a registered note stream.
module note_recorder #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned NOTE_W = 5,
  parameter int unsigned DUR_W  = 6,
  localparam int unsigned LEN_W  = $clog2(DEPTH + 1),
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              sys_CLK,
  input  logic              reset,
  input  logic              tick,
  input  logic [NOTE_W-1:0] live_note,
  input  logic              rec,
  input  logic              play,
  output logic [NOTE_W-1:0] note,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic              done,
  output logic [LEN_W-1:0]  rec_len
);

  localparam int unsigned ENT_W = NOTE_W + DUR_W;
  localparam logic [DUR_W-1:0] DUR_MAX = '1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRec, StPlay} state_e;

  state_e              state_q, state_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [NOTE_W-1:0]   cur_note_q, cur_note_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [DUR_W-1:0]    remain_q, remain_d;
  logic [LEN_W-1:0]    rec_len_q, rec_len_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic                full_q, full_d;
  logic                done_q, done_d;

  logic [ENT_W-1:0]    mem [DEPTH];

  logic                we_a, we_b;
  logic [ADDR_W-1:0]   addr_a, addr_b;
  logic [ENT_W-1:0]    data_a, data_b;
  logic [NOTE_W-1:0]   run_note;
  logic [DUR_W-1:0]    run_dur;
  logic [LEN_W-1:0]    len;
  logic [ADDR_W-1:0]   rd_inc;
  logic [LEN_W-1:0]    rd_inc_len;

  assign rd_inc     = rd_q + ADDR_W'(1);
  assign rd_inc_len = LEN_W'(rd_q) + LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    rec_len_d  = rec_len_q;
    rd_d       = rd_q;
    remain_d   = remain_q;
    cur_note_d = cur_note_q;
    dur_d      = dur_q;
    full_d     = full_q;
    done_d     = 1'b0;
    we_a       = 1'b0;
    we_b       = 1'b0;
    addr_a     = rec_len_q[ADDR_W-1:0];
    addr_b     = '0;
    data_a     = {cur_note_q, dur_q};
    data_b     = '0;
    run_note   = cur_note_q;
    run_dur    = dur_q;
    len        = rec_len_q;

    unique case (state_q)
      StIdle: begin
        if (rec) begin
          state_d   = StRec;
          rec_len_d = '0;
          full_d    = 1'b0;
          dur_d     = '0;
        end else if (play && (rec_len_q != '0)) begin
          state_d  = StPlay;
          rd_d     = '0;
          remain_d = mem[0][DUR_W-1:0];
        end
      end

      StRec: begin
        // The tick is applied first so a tick on the rec falling edge lands in the committed run.
        if (tick) begin
          if (dur_q == '0) begin
            run_note = live_note;
            run_dur  = DUR_W'(1);
          end else if ((live_note == cur_note_q) && (dur_q != DUR_MAX)) begin
            run_dur = dur_q + DUR_W'(1);
          end else begin
            we_a     = 1'b1;
            len      = rec_len_q + LEN_W'(1);
            run_note = live_note;
            run_dur  = DUR_W'(1);
          end
        end
        if (we_a && (len == DEPTH_L)) begin
          full_d  = 1'b1;
          state_d = StIdle;
          run_dur = '0;
        end else if (!rec) begin
          state_d = StIdle;
          if (run_dur != '0) begin
            we_b   = 1'b1;
            addr_b = len[ADDR_W-1:0];
            data_b = {run_note, run_dur};
            len    = len + LEN_W'(1);
            full_d = (len == DEPTH_L);
          end
        end
        cur_note_d = run_note;
        dur_d      = run_dur;
        rec_len_d  = len;
      end

      StPlay: begin
        if (!play) begin
          state_d = StIdle;
        end else if (tick) begin
          if (remain_q > DUR_W'(1)) begin
            remain_d = remain_q - DUR_W'(1);
          end else if (rd_inc_len == rec_len_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            rd_d     = rd_inc;
            remain_d = mem[rd_inc][DUR_W-1:0];
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // Looking at the next state/pointer keeps note exactly one cycle behind the decision.
    note_d = (state_d == StPlay) ? mem[rd_d][ENT_W-1:DUR_W] : live_note;
  end

  always_ff @(posedge sys_CLK) begin
    if (reset) begin
      state_q    <= StIdle;
      note_q     <= '0;
      rec_len_q  <= '0;
      rd_q       <= '0;
      remain_q   <= '0;
      cur_note_q <= '0;
      dur_q      <= '0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_q     <= note_d;
      rec_len_q  <= rec_len_d;
      rd_q       <= rd_d;
      remain_q   <= remain_d;
      cur_note_q <= cur_note_d;
      dur_q      <= dur_d;
      full_q     <= full_d;
      done_q     <= done_d;
    end
  end

  // Contents are deliberately left unreset; rec_len alone decides what is valid.
  always_ff @(posedge sys_CLK) begin
    if (we_a) mem[addr_a] <= data_a;
    if (we_b) mem[addr_b] <= data_b;
  end

  assign note      = note_q;
  assign recording = (state_q == StRec);
  assign playing   = (state_q == StPlay);
  assign full      = full_q;
  assign done      = done_q;
  assign rec_len   = rec_len_q;

endmodule
